id_ex_skid: RTL and testbench



---
 rtl/rv_pipe_pkg.sv | 34 +++
 rtl/pipe_skid_buf.sv | 62 ++++++
 rtl/id_ex_skid.sv | 100 ++++++++++
 tb/tb_id_ex_skid.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: control-bit layout of the decoded bundle,
// the decode->execute bundle struct, and small control-field helpers.
package rv_pipe_pkg;

  localparam int unsigned CTRL_W          = 7;
  localparam int unsigned CTRL_RS1_EN     = 0;
  localparam int unsigned CTRL_RS2_EN     = 1;
  localparam int unsigned CTRL_MEMREAD    = 2;
  localparam int unsigned CTRL_ALU_2ND_SRC = 3;
  localparam int unsigned CTRL_JAL        = 4;
  localparam int unsigned CTRL_JALR       = 5;
  localparam int unsigned CTRL_AUIPC      = 6;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned REG_ADDR_W = 5;

  // Decoded instruction bundle at the default widths; shared with operand select.
  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0]     rs1;
    logic [DATA_W-1:0]     rs2;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     imme;
  } id_ex_bundle_t;

  // True when the control word describes a memory load.
  function automatic logic ctrl_is_mem_read(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer (main + skid) with valid/ready on both
// sides and a synchronous flush. The main entry drives the outputs directly,
// so out_valid/out_data are registered. in_ready depends only on state and
// the external hold request, never on out_ready.
module pipe_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_r;
  logic             skid_valid_r;
  logic [WIDTH-1:0] main_data_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             accept_s;
  logic             main_free_s;

  assign in_ready    = !skid_valid_r && !hold;
  assign accept_s    = in_valid && in_ready;
  assign main_free_s = !main_valid_r || out_ready;
  assign out_valid   = main_valid_r;
  assign out_data    = main_data_r;

  // Main/skid state update; flush dominates, skid drains before new input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      main_data_r  <= {WIDTH{1'b0}};
      skid_data_r  <= {WIDTH{1'b0}};
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (main_free_s) begin
      if (skid_valid_r) begin
        main_data_r  <= skid_data_r;
        main_valid_r <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (accept_s) begin
        main_data_r  <= in_data;
        main_valid_r <= 1'b1;
      end else begin
        main_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      skid_data_r  <= in_data;
      skid_valid_r <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with a two-entry skid buffer.
// Optional load-use interlock compiled in with `define ID_EX_LOADUSE_EN:
// a consumer of a load destination is held at the input while the load sits
// in main and for one cycle after it leaves.
module id_ex_skid
  import rv_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [CTRL_W-1:0]         ctrl_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [DATA_WIDTH-1:0]     rs1_i,
  input  logic [DATA_WIDTH-1:0]     rs2_i,
  input  logic [DATA_WIDTH-1:0]     pc_i,
  input  logic [DATA_WIDTH-1:0]     imme_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [CTRL_W-1:0]         ctrl_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  output logic [DATA_WIDTH-1:0]     rs1_o,
  output logic [DATA_WIDTH-1:0]     rs2_o,
  output logic [DATA_WIDTH-1:0]     pc_o,
  output logic [DATA_WIDTH-1:0]     imme_o
);

  localparam int unsigned PAYLOAD_W = CTRL_W + 3 * REG_ADDR_WIDTH + 4 * DATA_WIDTH;

  logic [PAYLOAD_W-1:0] payload_in_s;
  logic [PAYLOAD_W-1:0] payload_out_s;
  logic                 hazard_s;

  // Flat packing keeps the buffer independent of the parameterised widths.
  assign payload_in_s = {ctrl_i, rd_i, rs1_addr_i, rs2_addr_i, rs1_i, rs2_i, pc_i, imme_i};
  assign {ctrl_o, rd_o, rs1_addr_o, rs2_addr_o, rs1_o, rs2_o, pc_o, imme_o} = payload_out_s;

`ifdef ID_EX_LOADUSE_EN
  logic                      mem_busy_q;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_q;
  logic                      fire_s;
  logic                      main_load_s;
  logic                      hit_main_s;
  logic                      hit_trk_s;

  assign fire_s      = out_valid_o && out_ready_i;
  assign main_load_s = out_valid_o && ctrl_is_mem_read(ctrl_o) &&
                       (rd_o != {REG_ADDR_WIDTH{1'b0}});
  assign hit_main_s  = main_load_s &&
                       ((ctrl_i[CTRL_RS1_EN] && (rs1_addr_i == rd_o)) ||
                        (ctrl_i[CTRL_RS2_EN] && (rs2_addr_i == rd_o)));
  assign hit_trk_s   = mem_busy_q &&
                       ((ctrl_i[CTRL_RS1_EN] && (rs1_addr_i == mem_rd_q)) ||
                        (ctrl_i[CTRL_RS2_EN] && (rs2_addr_i == mem_rd_q)));
  assign hazard_s    = in_valid_i && (hit_main_s || hit_trk_s);

  // Remember a departing load destination for exactly one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_busy_q <= 1'b0;
      mem_rd_q   <= {REG_ADDR_WIDTH{1'b0}};
    end else if (flush_i) begin
      mem_busy_q <= 1'b0;
    end else begin
      mem_busy_q <= fire_s && main_load_s;
      if (fire_s && main_load_s) begin
        mem_rd_q <= rd_o;
      end else begin
        mem_rd_q <= mem_rd_q;
      end
    end
  end
`else
  assign hazard_s = 1'b0;
`endif

  pipe_skid_buf #(
    .WIDTH(PAYLOAD_W)
  ) u_skid (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .hold      (hazard_s),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .in_data   (payload_in_s),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .out_data  (payload_out_s)
  );

endmodule

// File: tb/tb_id_ex_skid.sv
// Self-checking bench for id_ex_skid. A queue-based model holds the bundles
// currently inside the stage; the front of the queue is what execute must see.
module tb_id_ex_skid;
  import rv_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, in_valid_i, out_ready_i;
  logic        in_ready_o, out_valid_o;
  logic [6:0]  ctrl_o;
  logic [4:0]  rd_o, rs1_addr_o, rs2_addr_o;
  logic [63:0] rs1_o, rs2_o, pc_o, imme_o;
  id_ex_bundle_t cur;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  id_ex_bundle_t q[$];
  bit            trk_v;
  logic [4:0]    trk_rd;
  logic [63:0]   dut_log[$];
  int            fire_cyc[$];

  always #5 clk = ~clk;

  id_ex_skid dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ctrl_i(cur.ctrl), .rd_i(cur.rd), .rs1_addr_i(cur.rs1_addr), .rs2_addr_i(cur.rs2_addr),
    .rs1_i(cur.rs1), .rs2_i(cur.rs2), .pc_i(cur.pc), .imme_i(cur.imme),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ctrl_o(ctrl_o), .rd_o(rd_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .pc_o(pc_o), .imme_o(imme_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic id_ex_bundle_t mk(input logic [6:0] c, input logic [4:0] rd,
                                       input logic [4:0] a1, input logic [4:0] a2,
                                       input logic [63:0] pc);
    id_ex_bundle_t b;
    b.ctrl = c; b.rd = rd; b.rs1_addr = a1; b.rs2_addr = a2;
    b.rs1 = {$urandom(), $urandom()};
    b.rs2 = {$urandom(), $urandom()};
    b.pc = pc;
    b.imme = {$urandom(), $urandom()};
    return b;
  endfunction

  function automatic bit is_load(input id_ex_bundle_t b);
    return b.ctrl[CTRL_MEMREAD] && (b.rd != 5'd0);
  endfunction

  function automatic bit reads_reg(input id_ex_bundle_t b, input logic [4:0] r);
    return (b.ctrl[CTRL_RS1_EN] && b.rs1_addr == r) || (b.ctrl[CTRL_RS2_EN] && b.rs2_addr == r);
  endfunction

  // Expected in_ready from model occupancy and the load-use rule.
  function automatic bit exp_ready();
    bit hz = 1'b0;
`ifdef ID_EX_LOADUSE_EN
    if (in_valid_i) begin
      if (q.size() > 0 && is_load(q[0]) && reads_reg(cur, q[0].rd)) hz = 1'b1;
      if (trk_v && reads_reg(cur, trk_rd)) hz = 1'b1;
    end
`endif
    return (q.size() < 2) && !hz;
  endfunction

  task automatic check_model();
    chk("out_valid", {63'd0, out_valid_o}, {63'd0, q.size() > 0});
    chk("in_ready", {63'd0, in_ready_o}, {63'd0, exp_ready()});
    if (q.size() > 0) begin
      chk("ctrl", {57'd0, ctrl_o}, {57'd0, q[0].ctrl});
      chk("rd", {59'd0, rd_o}, {59'd0, q[0].rd});
      chk("rs1_addr", {59'd0, rs1_addr_o}, {59'd0, q[0].rs1_addr});
      chk("rs2_addr", {59'd0, rs2_addr_o}, {59'd0, q[0].rs2_addr});
      chk("rs1", rs1_o, q[0].rs1);
      chk("rs2", rs2_o, q[0].rs2);
      chk("pc", pc_o, q[0].pc);
      chk("imme", imme_o, q[0].imme);
    end
    if (out_valid_o && out_ready_i) begin
      dut_log.push_back(pc_o);
      fire_cyc.push_back(cyc);
    end
  endtask

  task automatic model_edge();
    bit acc;
    bit nt;
    acc = in_valid_i && exp_ready();
    if (flush_i) begin
      q.delete();
      trk_v = 1'b0;
    end else begin
      nt = 1'b0;
      if (q.size() > 0 && out_ready_i) begin
        nt = is_load(q[0]);
        if (nt) trk_rd = q[0].rd;
        void'(q.pop_front());
      end
      trk_v = nt;
      if (acc) q.push_back(cur);
    end
  endtask

  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    q.delete();
    trk_v = 1'b0;
    trk_rd = 5'd0;
  endtask

  initial begin
    bit acc;
    int idx;
    bit pat[4];
    id_ex_bundle_t stream[8];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    cur = mk(7'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    do_reset();

    // Reset state.
    #1;
    chk("rst_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst_ready", {63'd0, in_ready_o}, 64'd1);
    chk("rst_pc", pc_o, 64'd0);
    chk("rst_ctrl", {57'd0, ctrl_o}, 64'd0);
    chk("rst_imme", imme_o, 64'd0);
    @(negedge clk);

    // Single bundle, 1-cycle latency.
    cur = mk(7'd0, 5'd1, 5'd2, 5'd3, 64'h1000);
    cur.imme = 64'h10;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    chk("t1_valid", {63'd0, out_valid_o}, 64'd1);
    chk("t1_pc", pc_o, 64'h1000);
    chk("t1_imme", imme_o, 64'h10);
    step();
    chk("t1_empty", {63'd0, out_valid_o}, 64'd0);
    step();

    // Stream of 8 with toggling backpressure.
    for (int i = 0; i < 8; i++) stream[i] = mk(7'd0, 5'd1, 5'd2, 5'd3, 64'(i * 4));
    dut_log.delete();
    idx = 0;
    for (int c = 0; c < 60 && (idx < 8 || q.size() > 0); c++) begin
      out_ready_i = pat[c % 4];
      in_valid_i = (idx < 8);
      if (idx < 8) cur = stream[idx];
      acc = in_valid_i && exp_ready();
      step();
      if (acc) idx++;
    end
    in_valid_i = 1'b0;
    chk("t2_count", 64'(dut_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < dut_log.size(); i++) chk("t2_order", dut_log[i], 64'(i * 4));

    // Flush with both entries full and a simultaneous accept.
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    cur = mk(7'd0, 5'd1, 5'd2, 5'd3, 64'hA000); step();
    cur = mk(7'd0, 5'd1, 5'd2, 5'd3, 64'hA004); step();
    chk("t3_full", {63'd0, in_ready_o}, 64'd0);
    flush_i = 1'b1;
    cur = mk(7'd0, 5'd1, 5'd2, 5'd3, 64'hA008); step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    #1;
    chk("t3_valid", {63'd0, out_valid_o}, 64'd0);
    chk("t3_ready", {63'd0, in_ready_o}, 64'd1);
    dut_log.delete();
    repeat (4) step();
    chk("t3_no_leak", 64'(dut_log.size()), 64'd0);

    // Load rd=5 followed by a consumer of x5.
    dut_log.delete(); fire_cyc.delete();
    cur = mk(7'b0000100, 5'd5, 5'd0, 5'd0, 64'h2000);
    in_valid_i = 1'b1;
    step();
    cur = mk(7'b0000001, 5'd6, 5'd5, 5'd0, 64'h2004);
    for (int c = 0; c < 10; c++) begin
      acc = exp_ready();
      step();
      if (acc) break;
    end
    in_valid_i = 1'b0;
    repeat (3) step();
    chk("t4_count", 64'(dut_log.size()), 64'd2);
    if (dut_log.size() == 2) begin
      chk("t4_load", dut_log[0], 64'h2000);
      chk("t4_add", dut_log[1], 64'h2004);
`ifdef ID_EX_LOADUSE_EN
      chk("t4_gap", 64'(fire_cyc[1] - fire_cyc[0] > 1), 64'd1);
`else
      chk("t4_gap", 64'(fire_cyc[1] - fire_cyc[0]), 64'd1);
`endif
    end

    // Load rd=0 followed by a reader of x0: no stall.
    dut_log.delete(); fire_cyc.delete();
    in_valid_i = 1'b1;
    cur = mk(7'b0000100, 5'd0, 5'd0, 5'd0, 64'h3000); step();
    cur = mk(7'b0000001, 5'd7, 5'd0, 5'd0, 64'h3004); step();
    in_valid_i = 1'b0;
    repeat (2) step();
    chk("t5_count", 64'(dut_log.size()), 64'd2);
    if (fire_cyc.size() == 2) chk("t5_b2b", 64'(fire_cyc[1] - fire_cyc[0]), 64'd1);

    // Randomised traffic with occasional flush.
    for (int c = 0; c < 400; c++) begin
      in_valid_i = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 15) == 0);
      cur = mk(7'($urandom()), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), {$urandom(), $urandom()});
      step();
    end
    flush_i = 1'b0;
    in_valid_i = 1'b0;

    // Asynchronous reset with both entries valid.
    out_ready_i = 1'b0;
    repeat (2) step();
    in_valid_i = 1'b1;
    cur = mk(7'b1111111, 5'd9, 5'd1, 5'd2, 64'hB000); step();
    cur = mk(7'b1111111, 5'd9, 5'd1, 5'd2, 64'hB004); step();
    in_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("ar_valid", {63'd0, out_valid_o}, 64'd0);
    chk("ar_pc", pc_o, 64'd0);
    chk("ar_ctrl", {57'd0, ctrl_o}, 64'd0);
    chk("ar_rd", {59'd0, rd_o}, 64'd0);
    chk("ar_ready", {63'd0, in_ready_o}, 64'd1);
    #1 rst_i = 1'b0;
    q.delete();
    trk_v = 1'b0;
    @(negedge clk);
    out_ready_i = 1'b1;
    repeat (2) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
